// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480 timing defaults, widths, types and colour constants
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int COORD_W   = 10;
  localparam int RGB_W     = 3;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0] rgb_t;
  localparam rgb_t BLACK  = 3'b000;
  localparam rgb_t RED    = 3'b100;
  localparam rgb_t YELLOW = 3'b110;
  localparam rgb_t WHITE  = 3'b111;
  localparam rgb_t BLUE   = 3'b001;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel-coordinate/colour bus between the timing generator and graphics/DAC side
interface vga_sync_gen_if;
  import vga_pkg::*;
  rgb_t   rgb_in;
  rgb_t   rgb_out;
  coord_t x;
  coord_t y;
  logic   pix_tick;
  logic   frame_tick;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  modport master (
    input  rgb_in,
    output x, y, pix_tick, frame_tick, video_on, hsync, vsync, rgb_out
  );
  modport slave (
    output rgb_in,
    input  x, y, pix_tick, frame_tick, video_on, hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis counter with visible/sync/last decode
module vga_axis_cnt import vga_pkg::*; #(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output coord_t o_cnt,
  output logic   o_vis,
  output logic   o_sync_n,
  output logic   o_last
);
  localparam int     TOTAL   = DISPLAY + FRONT + SYNC + BACK;
  localparam coord_t C_DISP  = coord_t'(DISPLAY);
  localparam coord_t C_SYNC0 = coord_t'(DISPLAY + FRONT);
  localparam coord_t C_SYNC1 = coord_t'(DISPLAY + FRONT + SYNC - 1);
  localparam coord_t C_LAST  = coord_t'(TOTAL - 1);
  if (TOTAL > 1024 || TOTAL < 2) begin : g_bad_total
    $error("vga_axis_cnt: axis total must be 2..1024");
  end
  coord_t r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_en) r_cnt <= o_last ? '0 : r_cnt + coord_t'(1);
  assign o_cnt    = r_cnt;
  assign o_last   = r_cnt == C_LAST;
  assign o_vis    = r_cnt < C_DISP;
  assign o_sync_n = !(r_cnt >= C_SYNC0 && r_cnt <= C_SYNC1);
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel divider, x/y counters and registered blanked output stage
module vga_sync_gen #(
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter int PIX_DIV   = 2
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master bus
);
  import vga_pkg::*;
  localparam int            DW       = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: PIX_DIV must be at least 1");
  end
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_h_vis;
  logic          w_v_vis;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_vis;
  coord_t        w_h_cnt;
  coord_t        w_v_cnt;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  rgb_t          r_rgb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_div <= '0;
    else r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
  // gated by rst so the tick (and frame_tick) reads 0 while held in reset, even at PIX_DIV=1
  assign w_tick = rst && (r_div == DIV_LAST);
  vga_axis_cnt #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_tick),
    .o_cnt    (w_h_cnt),
    .o_vis    (w_h_vis),
    .o_sync_n (w_hs_n),
    .o_last   (w_h_last)
  );
  vga_axis_cnt #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_tick && w_h_last),
    .o_cnt    (w_v_cnt),
    .o_vis    (w_v_vis),
    .o_sync_n (w_vs_n),
    .o_last   (w_v_last)
  );
  assign w_vis = w_h_vis && w_v_vis;
  // output stage lags the counters by one pixel so colour and syncs stay aligned
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_video_on <= 1'b0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_rgb      <= BLACK;
    end else if (w_tick) begin
      r_video_on <= w_vis;
      r_hsync    <= w_hs_n;
      r_vsync    <= w_vs_n;
      r_rgb      <= w_vis ? bus.rgb_in : BLACK;
    end
  assign bus.x          = w_h_cnt;
  assign bus.y          = w_v_cnt;
  assign bus.pix_tick   = w_tick;
  assign bus.frame_tick = w_tick && w_h_last && w_v_last;
  assign bus.video_on   = r_video_on;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.rgb_out    = r_rgb;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for the default build plus a small-timing build and a PIX_DIV=1 build
module tb_vga_sync_gen;
  import vga_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();
  vga_sync_gen_if bus_c ();
  vga_sync_gen u_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIX_DIV(2)
  ) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));
  vga_sync_gen #(.PIX_DIV(1)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c.master));
  int n_checks = 0;
  int n_fail   = 0;
  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d got=%0d exp=%0d", name, tag, act, exp);
    end
  endtask
  typedef struct {
    int         tick;
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       von;
    logic [2:0] rgb;
    logic       ft;
  } exp_t;
  exp_t sb[$];
  exp_t e_a;
  function automatic void push(int t, int x, int y, logic hs, logic vs, logic von, logic [2:0] rgb, logic ft);
    sb.push_back('{t, x, y, hs, vs, von, rgb, ft});
  endfunction
  logic arm_a  = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  logic done_c = 1'b0;
  int   tick_a = -1;
  int   hs_low_a = 0;
  always @(negedge clk) begin
    if (arm_a && bus_a.pix_tick) begin
      tick_a++;
      if (tick_a >= 1 && tick_a <= 800 && !bus_a.hsync) hs_low_a++;
      if (tick_a == 801) chk("A_hsync_low_ticks", tick_a, hs_low_a, 96);
      if (sb.size() > 0 && sb[0].tick == tick_a) begin
        e_a = sb.pop_front();
        chk("A_x",          tick_a, bus_a.x,          e_a.x);
        chk("A_y",          tick_a, bus_a.y,          e_a.y);
        chk("A_hsync",      tick_a, bus_a.hsync,      e_a.hs);
        chk("A_vsync",      tick_a, bus_a.vsync,      e_a.vs);
        chk("A_video_on",   tick_a, bus_a.video_on,   e_a.von);
        chk("A_rgb_out",    tick_a, bus_a.rgb_out,    e_a.rgb);
        chk("A_frame_tick", tick_a, bus_a.frame_tick, e_a.ft);
      end
    end
  end
  initial begin
    bus_a.rgb_in = WHITE;
    //   tick  x    y  hs vs von rgb     ft
    push(0,    0,   0, 1, 1, 0, 3'b000, 0);
    push(1,    1,   0, 1, 1, 1, 3'b101, 0);
    push(639,  639, 0, 1, 1, 1, 3'b101, 0);
    push(640,  640, 0, 1, 1, 1, 3'b101, 0);
    push(641,  641, 0, 1, 1, 0, 3'b000, 0);
    push(656,  656, 0, 1, 1, 0, 3'b000, 0);
    push(657,  657, 0, 0, 1, 0, 3'b000, 0);
    push(752,  752, 0, 0, 1, 0, 3'b000, 0);
    push(753,  753, 0, 1, 1, 0, 3'b000, 0);
    push(799,  799, 0, 1, 1, 0, 3'b000, 0);
    push(800,  0,   1, 1, 1, 0, 3'b000, 0);
    push(801,  1,   1, 1, 1, 1, 3'b101, 0);
    repeat (3) @(negedge clk);
    chk("A_rst_x",          0, bus_a.x,          0);
    chk("A_rst_y",          0, bus_a.y,          0);
    chk("A_rst_pix_tick",   0, bus_a.pix_tick,   0);
    chk("A_rst_frame_tick", 0, bus_a.frame_tick, 0);
    chk("A_rst_video_on",   0, bus_a.video_on,   0);
    chk("A_rst_hsync",      0, bus_a.hsync,      1);
    chk("A_rst_vsync",      0, bus_a.vsync,      1);
    chk("A_rst_rgb_out",    0, bus_a.rgb_out,    0);
    bus_a.rgb_in = 3'b101;
    rst_a = 1'b1;
    arm_a = 1'b1;
    #1 chk("A_no_tick_at_release", 0, bus_a.pix_tick, 0);
    for (int i = 0; i < 4000 && sb.size() > 0; i++) @(negedge clk);
    chk("A_scoreboard_drained", 0, sb.size(), 0);
    done_a = 1'b1;
  end
  int         b_ticks = 0;
  int         b_fts = 0;
  int         b_ft_bad = 0;
  int         b_vs_low = 0;
  int         b_vs_bad = 0;
  int         b_hs_low = 0;
  logic [9:0] b_py = '0;
  logic       b_found = 1'b0;
  initial begin
    bus_b.rgb_in = YELLOW;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 1000 && b_ticks < 384; i++) begin
      @(negedge clk);
      if (bus_b.frame_tick) begin
        b_fts++;
        if (!(bus_b.pix_tick && bus_b.x == 10'd15 && bus_b.y == 10'd11)) b_ft_bad++;
      end
      if (bus_b.pix_tick) begin
        if (b_ticks > 0 && !bus_b.vsync) begin
          b_vs_low++;
          if (b_py != 10'd8 && b_py != 10'd9) b_vs_bad++;
        end
        if (b_ticks > 0 && !bus_b.hsync) b_hs_low++;
        b_py = bus_b.y;
        b_ticks++;
      end
    end
    chk("B_ticks",          0, b_ticks,  384);
    chk("B_frame_ticks",    0, b_fts,    2);
    chk("B_frame_tick_pos", 0, b_ft_bad, 0);
    chk("B_vsync_low",      0, b_vs_low, 64);
    chk("B_vsync_lines",    0, b_vs_bad, 0);
    chk("B_hsync_low",      0, b_hs_low, 72);
    @(negedge clk);
    for (int i = 0; i < 8 && !bus_b.pix_tick; i++) @(negedge clk);
    chk("B_wrap_x",  0, bus_b.x,          0);
    chk("B_wrap_y",  0, bus_b.y,          0);
    chk("B_wrap_ft", 0, bus_b.frame_tick, 0);
    for (int i = 0; i < 600 && !b_found; i++) begin
      @(negedge clk);
      b_found = bus_b.pix_tick && bus_b.x == 10'd5 && bus_b.y == 10'd3;
    end
    chk("B_reached_5_3", 0, b_found, 1);
    chk("B_pre_video_on", 0, bus_b.video_on, 1);
    chk("B_pre_rgb_out",  0, bus_b.rgb_out,  YELLOW);
    #1 rst_b = 1'b0;
    #1;
    chk("B_async_x",          1, bus_b.x,          0);
    chk("B_async_y",          1, bus_b.y,          0);
    chk("B_async_pix_tick",   1, bus_b.pix_tick,   0);
    chk("B_async_frame_tick", 1, bus_b.frame_tick, 0);
    chk("B_async_video_on",   1, bus_b.video_on,   0);
    chk("B_async_hsync",      1, bus_b.hsync,      1);
    chk("B_async_vsync",      1, bus_b.vsync,      1);
    chk("B_async_rgb_out",    1, bus_b.rgb_out,    0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("B_restart_tick", 2, bus_b.pix_tick, 1);
    chk("B_restart_x",    2, bus_b.x,        0);
    chk("B_restart_y",    2, bus_b.y,        0);
    repeat (2) @(negedge clk);
    chk("B_second_x",        3, bus_b.x,        1);
    chk("B_second_video_on", 3, bus_b.video_on, 1);
    chk("B_second_rgb_out",  3, bus_b.rgb_out,  YELLOW);
    done_b = 1'b1;
  end
  int c_lows = 0;
  initial begin
    bus_c.rgb_in = BLUE;
    repeat (2) @(negedge clk);
    chk("C_tick_in_reset", 0, bus_c.pix_tick, 0);
    rst_c = 1'b1;
    #1 chk("C_tick_at_release", 0, bus_c.pix_tick, 1);
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (!bus_c.pix_tick) c_lows++;
      if (i == 799) begin
        chk("C_x_799", i, bus_c.x, 799);
        chk("C_y_799", i, bus_c.y, 0);
      end
      if (i == 800) begin
        chk("C_x_wrap", i, bus_c.x, 0);
        chk("C_y_wrap", i, bus_c.y, 1);
      end
    end
    chk("C_tick_gaps", 0, c_lows, 0);
    done_c = 1'b1;
  end
  initial begin
    for (int i = 0; i < 20000 && !(done_a && done_b && done_c); i++) @(negedge clk);
    chk("all_done", 0, {done_a, done_b, done_c}, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
